// File: rtl/cpu_input_port_pkg.sv
// Shared definitions for the CPU serial input port: receiver FSM state encodings.
`timescale 1ns/1ps
package cpu_input_port_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; resets to 1 (idle line level).
`timescale 1ns/1ps
module sync_2ff (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cpu_input_port.sv
// Serial receiver feeding a cpu_register: start/data/stop framing, one-cycle
// data and framing-error strobes. WIDTH >= 2; CLKS_PER_BIT even and >= 4.
//
// state | meaning
// IDLE  | line idle, waiting for a 1-to-0 edge on rx_s
// START | half-bit wait, then confirm start bit is still low
// DATA  | sample one data bit per bit time, LSB first
// STOP  | sample stop bit; high loads data_out, low flags framing error
`timescale 1ns/1ps
module cpu_input_port
  import cpu_input_port_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rx,
  output logic [WIDTH-1:0] data_out,
  output logic             data_out_en,
  output logic             framing_error,
  output logic             busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  rx_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] bit_idx;
  logic [WIDTH-1:0] shreg;
  logic             rx_s, rx_prev, fall, tick;

  sync_2ff u_sync (
    .clock (clock),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  // rx_prev tracks rx_s in every state so a break cannot look like a new edge
  assign fall = rx_prev & ~rx_s;

  always_comb begin
    tick = 1'b0;
    case (state)
      START:      tick = (cnt == HALF_M1);
      DATA, STOP: tick = (cnt == FULL_M1);
      default:    tick = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      data_out      <= '0;
      data_out_en   <= 1'b0;
      framing_error <= 1'b0;
      rx_prev       <= 1'b1;
    end else begin
      state         <= state_nxt;
      rx_prev       <= rx_s;
      data_out_en   <= 1'b0;
      framing_error <= 1'b0;

      if (state == IDLE || tick) cnt <= '0;
      else                       cnt <= cnt + CNT_W'(1);

      case (state)
        IDLE: bit_idx <= '0;
        DATA: begin
          if (tick) begin
            shreg   <= {rx_s, shreg[WIDTH-1:1]};
            bit_idx <= (bit_idx == LAST_IDX) ? '0 : bit_idx + IDX_W'(1);
          end
        end
        STOP: begin
          if (tick) begin
            if (rx_s) begin
              data_out    <= shreg;
              data_out_en <= 1'b1;
            end else begin
              framing_error <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (fall) state_nxt = START;
      START: if (tick) state_nxt = rx_s ? IDLE : DATA;
      DATA:  if (tick && bit_idx == LAST_IDX) state_nxt = STOP;
      STOP:  if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

endmodule

// File: tb/tb_cpu_input_port.sv
// Directed bench for cpu_input_port: table of clean/bad frames plus hand sequences
// for glitch, back-to-back, mid-frame reset and break conditions.
`timescale 1ns/1ps
module tb_cpu_input_port;

  localparam int WIDTH = 8;
  localparam int CPB   = 16;

  logic             clock = 1'b0;
  logic             reset;
  logic             rx;
  logic [WIDTH-1:0] data_out;
  logic             data_out_en;
  logic             framing_error;
  logic             busy;

  int checks = 0;
  int errors = 0;

  int          en_cnt = 0;
  int          fe_cnt = 0;
  int          both_cnt = 0;
  int          en_log[$];
  logic        busy_seen = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_en;
    int         exp_fe;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs[5];

  always #5 clock = ~clock;

  cpu_input_port #(.WIDTH(WIDTH), .CLKS_PER_BIT(CPB)) dut (
    .clock         (clock),
    .reset         (reset),
    .rx            (rx),
    .data_out      (data_out),
    .data_out_en   (data_out_en),
    .framing_error (framing_error),
    .busy          (busy)
  );

  always @(negedge clock) begin
    if (!reset) begin
      if (data_out_en) begin
        en_cnt++;
        en_log.push_back(int'(data_out));
      end
      if (framing_error) fe_cnt++;
      if (data_out_en && framing_error) both_cnt++;
      if (busy) busy_seen = 1'b1;
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int gap_bits);
    send_bit(1'b0);
    for (int i = 0; i < WIDTH; i++) send_bit(d[i]);
    send_bit(stop);
    for (int i = 0; i < gap_bits; i++) send_bit(1'b1);
  endtask

  int en0, fe0;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
    vecs[1] = '{8'h3C, 1'b0, 0, 1, 8'hA5};
    vecs[2] = '{8'h00, 1'b1, 1, 0, 8'h00};
    vecs[3] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    vecs[4] = '{8'h5A, 1'b1, 1, 0, 8'h5A};

    reset = 1'b1;
    rx    = 1'b1;
    repeat (4) @(negedge clock);
    check("reset_data_out", int'(data_out), 0);
    check("reset_en", int'(data_out_en), 0);
    check("reset_fe", int'(framing_error), 0);
    check("reset_busy", int'(busy), 0);
    reset = 1'b0;
    repeat (4) @(negedge clock);

    for (int v = 0; v < 5; v++) begin
      en0 = en_cnt;
      fe0 = fe_cnt;
      send_frame(vecs[v].data, vecs[v].stop, 2);
      check($sformatf("vec%0d_en_pulses", v), en_cnt - en0, vecs[v].exp_en);
      check($sformatf("vec%0d_fe_pulses", v), fe_cnt - fe0, vecs[v].exp_fe);
      check($sformatf("vec%0d_data_out", v), int'(data_out), int'(vecs[v].exp_dout));
    end

    // 4-clock low glitch in idle
    en0 = en_cnt; fe0 = fe_cnt; busy_seen = 1'b0;
    rx = 1'b0;
    repeat (4) @(negedge clock);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clock);
    check("glitch_busy_seen", int'(busy_seen), 1);
    check("glitch_busy_now", int'(busy), 0);
    check("glitch_en", en_cnt - en0, 0);
    check("glitch_fe", fe_cnt - fe0, 0);
    check("glitch_data_out", int'(data_out), 8'h5A);

    // back-to-back frames, zero gap
    en0 = en_cnt; fe0 = fe_cnt;
    send_frame(8'h01, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 2);
    check("b2b_en", en_cnt - en0, 2);
    check("b2b_fe", fe_cnt - fe0, 0);
    if (en_log.size() >= 2) begin
      check("b2b_first", en_log[en_log.size()-2], 8'h01);
      check("b2b_second", en_log[en_log.size()-1], 8'hFF);
    end else begin
      check("b2b_log_size", en_log.size(), 2);
    end

    // reset during data bit 4 of 0x55
    en0 = en_cnt; fe0 = fe_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(((8'h55 >> i) & 8'h01) != 0);
    rx = 1'b1;
    repeat (CPB / 2) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("midrst_data_out", int'(data_out), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_en", int'(data_out_en), 0);
    reset = 1'b0;
    repeat (2 * CPB) @(negedge clock);
    check("midrst_no_strobe", en_cnt - en0, 0);
    send_frame(8'h81, 1'b1, 2);
    check("after_rst_en", en_cnt - en0, 1);
    check("after_rst_data", int'(data_out), 8'h81);
    check("after_rst_fe", fe_cnt - fe0, 0);

    // framing error followed by a 40 bit-time break
    en0 = en_cnt; fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0, 0);
    repeat (CPB) @(negedge clock);
    check("break_fe", fe_cnt - fe0, 1);
    check("break_data_kept", int'(data_out), 8'h81);
    fe0 = fe_cnt; busy_seen = 1'b0;
    repeat (40 * CPB) @(negedge clock);
    check("break_no_fe", fe_cnt - fe0, 0);
    check("break_no_en", en_cnt - en0, 0);
    check("break_not_busy", int'(busy_seen), 0);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clock);
    send_frame(8'h42, 1'b1, 2);
    check("post_break_en", en_cnt - en0, 1);
    check("post_break_data", int'(data_out), 8'h42);

    check("never_both_strobes", both_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_input_port.md
CPU_INPUT_PORT -- requirements
Module: cpu_input_port

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the data word width in bits.
REQ-002 The module SHALL have parameter CLKS_PER_BIT, default 16, giving clocks per serial bit; it must be even and >= 4.
REQ-003 Port clock: input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 Port reset: input, 1 bit, synchronous, active-high reset.
REQ-005 Port rx: input, 1 bit, asynchronous serial line, idle high.
REQ-006 Port data_out: output, WIDTH bits, last correctly framed word; drives a cpu_register data_in.
REQ-007 Port data_out_en: output, 1 bit, one-cycle strobe marking data_out as newly valid; drives a cpu_register data_in_en.
REQ-008 Port framing_error: output, 1 bit, one-cycle strobe on bad stop bit.
REQ-009 Port busy: output, 1 bit, high whenever the state is not IDLE.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value rx_s (2-cycle latency).
REQ-011 FSM states SHALL be IDLE, START, DATA, STOP; a clock counter of width clog2(CLKS_PER_BIT) and a bit index of width clog2(WIDTH) SHALL drive transitions.
REQ-012 IDLE -> START only on a 1-to-0 transition of rx_s; a line held low (break) SHALL NOT retrigger.
REQ-013 START: after CLKS_PER_BIT/2 clocks, sample rx_s; 0 -> DATA with counter cleared; 1 -> IDLE (glitch rejected, no strobe).
REQ-014 DATA: every CLKS_PER_BIT clocks sample rx_s into the shift register, LSB first; after the WIDTH-th sample -> STOP.
REQ-015 STOP: after CLKS_PER_BIT clocks, sample rx_s; 1 -> load data_out and assert data_out_en; 0 -> assert framing_error, data_out unchanged; both -> IDLE.
REQ-016 data_out_en and framing_error SHALL be high for exactly one clock, the clock after the stop sample, and never simultaneously.
REQ-017 data_out SHALL hold its value between strobes; partially received bits SHALL never appear on data_out.
REQ-018 A new start edge SHALL be accepted in the clock immediately after returning to IDLE (back-to-back frames, no gap).
REQ-019 Counter and bit index SHALL wrap only through explicit clearing on state transitions; no modular overflow is used.

Reset
REQ-020 While reset is high at a clock edge: state IDLE, counter 0, bit index 0, shift register 0, data_out 0, data_out_en 0, framing_error 0, busy 0, synchronizer flops 1.
REQ-021 Reset mid-frame SHALL abort the frame with no strobe; reception resumes only on the next 1-to-0 edge after reset deasserts.

Structure
REQ-022 State encodings (IDLE=0, START=1, DATA=2, STOP=3) SHALL live in the shared cpu definitions package/include, not in the module.
REQ-023 The synchronizer SHALL be a separate sub-module sync_2ff (parameterless, 1 bit, reset value 1).
REQ-024 The block SHALL contain no combinational path from rx to any output.

Verification (WIDTH=8, CLKS_PER_BIT=16)
REQ-025 Frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop=1) -> single data_out_en pulse, data_out=0xA5, framing_error 0.
REQ-026 Frame 0x3C with stop bit 0 -> framing_error one-cycle pulse, data_out keeps prior 0xA5, no data_out_en.
REQ-027 rx low pulse of 4 clocks in IDLE -> return to IDLE from START, no strobes, busy pulse only.
REQ-028 Frames 0x01 then 0xFF with zero idle gap -> two data_out_en pulses, data_out 0x01 then 0xFF.
REQ-029 Reset asserted at data bit 4 of 0x55, then frame 0x81 -> no strobe for 0x55, data_out=0x81 after second frame; outputs 0 during reset.
REQ-030 rx held low 40 bit-times after a framing error -> no further strobes until rx high then a new falling edge.
